// File: rtl/ysyx_25030077_halt_ctrl_if.sv
// Commit-to-halt-controller bundle: retiring-instruction inputs and halt/trace outputs.
// master = commit side driving retire info; slave = halt controller.
interface ysyx_25030077_halt_ctrl_if #(
    parameter int CNT_W = 64
);
    logic             inst_valid;
    logic [31:0]      inst;
    logic [31:0]      pc;
    logic [31:0]      a0;
    logic             lsu_busy;
    logic             stall_req;
    logic             is_break_out;
    logic             is_unknown_instruction;
    logic             halted;
    logic [31:0]      halt_pc;
    logic [31:0]      halt_code;
    logic [CNT_W-1:0] inst_count;
    logic [CNT_W-1:0] cycle_count;

    modport master (
        output inst_valid, inst, pc, a0, lsu_busy,
        input  stall_req, is_break_out, is_unknown_instruction, halted,
        input  halt_pc, halt_code, inst_count, cycle_count
    );

    modport slave (
        input  inst_valid, inst, pc, a0, lsu_busy,
        output stall_req, is_break_out, is_unknown_instruction, halted,
        output halt_pc, halt_code, inst_count, cycle_count
    );
endinterface

// File: rtl/ysyx_25030077_halt_ctrl.sv
// Halt controller: traps on ebreak/illegal opcode, drains stores, pulses the exit block once.
// Latency: stall 1 cycle after trap, pulse DRAIN_CYCLES+1 cycles after trap; lsu_busy stretches drain.
module ysyx_25030077_halt_ctrl #(
    parameter int DRAIN_CYCLES = 4,
    parameter int CNT_W        = 64
) (
    input  logic                      clock,
    input  logic                      reset,
    ysyx_25030077_halt_ctrl_if.slave  hc
);
    typedef enum logic [1:0] {RUN, DRAIN, REPORT, HALTED} state_e;

    localparam int          DW         = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DW-1:0] DRAIN_INIT = DW'(DRAIN_CYCLES - 1);
    localparam logic [31:0] EBREAK     = 32'h0010_0073;

    state_e           state_q, state_d;
    logic [DW-1:0]    drain_q, drain_d;
    logic             cause_brk_q, cause_brk_d;
    logic [31:0]      halt_pc_q, halt_pc_d;
    logic [31:0]      halt_code_q, halt_code_d;
    logic [CNT_W-1:0] inst_cnt_q, inst_cnt_d;
    logic [CNT_W-1:0] cyc_cnt_q, cyc_cnt_d;

    logic is_ebreak;
    logic is_legal;

    assign is_ebreak = (hc.inst == EBREAK);

    // Only the major opcode is decoded; funct fields never make a word illegal.
    always_comb begin
        is_legal = 1'b0;
        case (hc.inst[6:0])
            7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111,
            7'b1100011, 7'b0000011, 7'b0100011, 7'b0010011,
            7'b0110011, 7'b0001111, 7'b1110011: is_legal = 1'b1;
            default:                            is_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= RUN;
            drain_q     <= '0;
            cause_brk_q <= 1'b0;
            halt_pc_q   <= '0;
            halt_code_q <= '0;
            inst_cnt_q  <= '0;
            cyc_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            drain_q     <= drain_d;
            cause_brk_q <= cause_brk_d;
            halt_pc_q   <= halt_pc_d;
            halt_code_q <= halt_code_d;
            inst_cnt_q  <= inst_cnt_d;
            cyc_cnt_q   <= cyc_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        drain_d     = drain_q;
        cause_brk_d = cause_brk_q;
        halt_pc_d   = halt_pc_q;
        halt_code_d = halt_code_q;
        inst_cnt_d  = inst_cnt_q;
        cyc_cnt_d   = cyc_cnt_q;

        if (state_q != HALTED) begin
            cyc_cnt_d = cyc_cnt_q + CNT_W'(1);
        end

        case (state_q)
            RUN: begin
                if (hc.inst_valid) begin
                    if (is_legal) begin
                        inst_cnt_d = inst_cnt_q + CNT_W'(1);
                    end
                    if (is_ebreak || !is_legal) begin
                        state_d     = DRAIN;
                        drain_d     = DRAIN_INIT;
                        cause_brk_d = is_ebreak;
                        halt_pc_d   = hc.pc;
                        halt_code_d = is_ebreak ? hc.a0 : hc.inst;
                    end
                end
            end
            DRAIN: begin
                if (drain_q != '0) begin
                    drain_d = drain_q - DW'(1);
                end else if (!hc.lsu_busy) begin
                    state_d = REPORT;
                end
            end
            REPORT:  state_d = HALTED;
            default: state_d = HALTED;
        endcase
    end

    always_comb begin
        hc.stall_req              = (state_q != RUN);
        hc.is_break_out           = (state_q == REPORT) && cause_brk_q;
        hc.is_unknown_instruction = (state_q == REPORT) && !cause_brk_q;
        hc.halted                 = (state_q == HALTED);
    end

    assign hc.halt_pc     = halt_pc_q;
    assign hc.halt_code   = halt_code_q;
    assign hc.inst_count  = inst_cnt_q;
    assign hc.cycle_count = cyc_cnt_q;
endmodule

// File: doc/ysyx_25030077_halt_ctrl.md
# ysyx_25030077_halt_ctrl

Halt controller between commit and the simulation-exit block. Watches each retiring instruction, detects `ebreak` and unrecognised opcodes, and freezes the core. It then drains outstanding stores and emits a one-cycle `is_break_out` or `is_unknown_instruction` pulse to the exit block. It also keeps retired-instruction and cycle counters, and latches the halt PC and exit code for the difftest/trace side.

## Interface
- `DRAIN_CYCLES`, default 4: minimum cycles spent draining after a trap; legal range ≥ 1.
- `CNT_W`, default 64: width of both performance counters.

- `clock`  in  1  — single clock; all state updates on posedge.
- `reset`  in  1  — synchronous, active-high.
- `inst_valid`  in  1  — an instruction retires this cycle.
- `inst`  in  32  — retiring instruction word.
- `pc`  in  32  — PC of retiring instruction.
- `a0`  in  32  — current value of x10.
- `lsu_busy`  in  1  — a store is still outstanding.
- `stall_req`  out  1  — freezes fetch and commit.
- `is_break_out`  out  1  — one-cycle pulse; the trap was `ebreak`.
- `is_unknown_instruction`  out  1  — one-cycle pulse; the trap was an illegal opcode.
- `halted`  out  1  — sticky halt flag.
- `halt_pc`  out  32  — PC of the trapping instruction.
- `halt_code`  out  32  — `a0` for `ebreak`; the instruction word for an illegal opcode.
- `inst_count`  out  CNT_W  — count of legally retired instructions.
- `cycle_count`  out  CNT_W  — cycles since reset, excluding HALTED.

## Operation
- **`ebreak` detect:** `inst == 32'h0010_0073` exactly.
- **Illegal detect:** `inst[6:0]` is not one of 0110111, 0010111, 1101111, 1100111, 1100011, 0000011, 0100011, 0010011, 0110011, 0001111, 1110011. An `inst[1:0] != 2'b11` word is covered by this rule. Funct fields are not checked.
- **FSM states:** RUN, DRAIN, REPORT, HALTED. Register fields: 2-bit state, drain counter, cause bit.
- **RUN:**
  - `inst_valid` with a legal instruction (including `ebreak`): `inst_count` += 1.
  - `inst_valid` with `ebreak`: latch `halt_pc`=`pc`, `halt_code`=`a0`, cause=BRK; load drain counter with `DRAIN_CYCLES-1`; go to DRAIN.
  - `inst_valid` with an illegal opcode: latch `halt_pc`=`pc`, `halt_code`=`inst`, cause=ILL; do not count; load drain counter; go to DRAIN.
- **DRAIN:**
  - Counter decrements each cycle and saturates at 0.
  - Go to REPORT when counter == 0 and `lsu_busy` == 0. Otherwise stay.
- **REPORT:** lasts exactly one cycle. Assert `is_break_out` if cause=BRK, else `is_unknown_instruction`. Go to HALTED.
- **HALTED:** absorbing until reset. `halted`=1.
- **Ignored inputs:** `inst_valid` is ignored in DRAIN, REPORT and HALTED. No counting, no re-latching.
- **`stall_req`:** equals (state != RUN). Registered decode, no combinational path from `inst`.
- **`cycle_count`:** increments every cycle in RUN, DRAIN and REPORT. Frozen in HALTED.
- **Counter width:** both counters wrap modulo 2^CNT_W.
- **`halt_pc` / `halt_code`:** hold their value until reset.

## Timing
- **Reset values:** state=RUN; all outputs 0, including both counters, `halt_pc` and `halt_code`.
- **Reset mid-operation:** reset in any state returns to RUN on the next edge. It clears everything and no pulse is emitted.
- **Cycle sequence** for a trap retiring in cycle T with `lsu_busy`=0:

| Cycle(s) | State | Observable |
|---|---|---|
| T+1 | DRAIN | `stall_req`=1; `halt_pc` and `halt_code` valid |
| T+1 … T+DRAIN_CYCLES | DRAIN | stays DRAIN_CYCLES cycles |
| T+DRAIN_CYCLES+1 | REPORT | pulse high for one cycle |
| T+DRAIN_CYCLES+2 onward | HALTED | `halted`=1 |

- **`lsu_busy`** extends DRAIN cycle-for-cycle. REPORT follows in the cycle after the first cycle in which `lsu_busy` is sampled 0 with the counter at 0.
- **Pulse exclusivity:** the two pulses are never high together and never high outside REPORT.
- **Final counter values:** `cycle_count` at halt equals the number of non-reset cycles through REPORT.

## Test plan
- **Reset:** hold reset 3 cycles, then idle 2 cycles → all outputs 0, `cycle_count`=2 after the two idle edges.
- **`ebreak` trap:** 5 `addi` (`0x00100093`) retire back-to-back, then `ebreak` at pc `0x8000_0014` with `a0`=0; `DRAIN_CYCLES`=4, `lsu_busy`=0.
  - `is_break_out` pulses exactly at T+5; `halted`=1 from T+6.
  - `inst_count`=6, `halt_pc`=`0x8000_0014`, `halt_code`=0.
- **Illegal trap:** `inst`=`0x0000_0000` at pc `0x8000_0004`, after 1 legal instruction.
  - `is_unknown_instruction` pulses at T+5; `is_break_out` stays 0.
  - `halt_code`=0, `inst_count`=1.
- **Store drain:** `ebreak` with `lsu_busy` held high for 10 cycles after T → pulse at T+11, not T+5; `stall_req`=1 throughout.
- **Reset mid-DRAIN:** assert reset at T+2 → RUN after the reset edge; no pulse ever; counters 0. A following `ebreak` halts normally.
- **Ignore and wrap:** with `CNT_W`=4, 17 legal retires → `inst_count`=1. While HALTED, drive `inst_valid` with an illegal opcode for 5 cycles → no pulse, `halt_pc`/`inst_count`/`cycle_count` unchanged.
